// File: rtl/memory_access_unit_pkg.sv
// Shared CPU definitions used by the memory stage.
package memory_access_unit_pkg;

  localparam int unsigned WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mau_state_t;

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts ACCESS cycles spent waiting for a memory acknowledge.
module mem_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal_c
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // terminal_c flags the last permitted waiting cycle, so the count saturates there
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !terminal_c) begin
      count <= count + CNT_W'(1);
    end
  end

  assign terminal_c = (count == LAST);

endmodule

// File: rtl/memory_access_unit.sv
// Memory pipeline stage: issues load/store requests, stalls upstream while
// waiting for the data memory, and registers results into writeback.
module memory_access_unit
  import memory_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wre_memory,
  input  logic              select_writeback_data_mux_memory,
  input  logic              write_memory_enable_memory,
  input  logic [WORD_W-1:0] ALUresult_memory,
  input  logic [WORD_W-1:0] srcB_memory,
  input  logic [WORD_W-1:0] rd_memory,
  output logic              mem_req,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              stall_memory,
  output logic              wre_writeback,
  output logic [WORD_W-1:0] writeback_data,
  output logic [WORD_W-1:0] rd_writeback,
  output logic              mem_error
);

  mau_state_t        state;
  mau_state_t        state_next;
  logic [WORD_W-1:0] load_data;
  logic              mem_op_c;
  logic              start_c;
  logic              wait_c;
  logic              ack_c;
  logic              timeout_c;
  logic              tc_c;

  assign mem_op_c  = select_writeback_data_mux_memory | write_memory_enable_memory;
  assign start_c   = (state == IDLE) && mem_op_c;
  assign wait_c    = (state == ACCESS) && !mem_ack;
  assign ack_c     = (state == ACCESS) && mem_ack;
  assign timeout_c = wait_c && tc_c;

  // Stall is combinational so the instruction is held from its first cycle here
  assign stall_memory = !reset && (start_c || (state == ACCESS));

  mem_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .clear     (start_c),
    .enable    (wait_c),
    .terminal_c(tc_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (mem_op_c) state_next = ACCESS;
      ACCESS:  if (ack_c || timeout_c) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // mem_we stays valid through DONE and doubles as the store flag there
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      wre_writeback  <= 1'b0;
      writeback_data <= '0;
      rd_writeback   <= '0;
      mem_error      <= 1'b0;
      load_data      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op_c) begin
            mem_req       <= 1'b1;
            mem_we        <= write_memory_enable_memory;
            mem_addr      <= ALUresult_memory;
            mem_wdata     <= srcB_memory;
            wre_writeback <= 1'b0;
          end else begin
            writeback_data <= ALUresult_memory;
            rd_writeback   <= rd_memory;
            wre_writeback  <= wre_memory;
          end
        end
        ACCESS: begin
          if (ack_c) begin
            mem_req   <= 1'b0;
            load_data <= mem_rdata;
          end else if (timeout_c) begin
            mem_req   <= 1'b0;
            mem_error <= 1'b1;
            load_data <= '0;
          end
        end
        DONE: begin
          writeback_data <= mem_we ? ALUresult_memory : load_data;
          rd_writeback   <= rd_memory;
          wre_writeback  <= wre_memory & ~mem_we;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_unit.sv
// Bench for memory_access_unit: directed scenarios plus random instruction
// stream checked against a transaction-level model of the memory stage.
module tb_memory_access_unit;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wre_memory;
  logic        select_writeback_data_mux_memory;
  logic        write_memory_enable_memory;
  logic [15:0] ALUresult_memory;
  logic [15:0] srcB_memory;
  logic [15:0] rd_memory;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        stall_memory;
  logic        wre_writeback;
  logic [15:0] writeback_data;
  logic [15:0] rd_writeback;
  logic        mem_error;

  int   vectors     = 0;
  int   miscompares = 0;
  logic exp_err     = 1'b0;

  memory_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk                             (clk),
    .reset                           (reset),
    .wre_memory                      (wre_memory),
    .select_writeback_data_mux_memory(select_writeback_data_mux_memory),
    .write_memory_enable_memory      (write_memory_enable_memory),
    .ALUresult_memory                (ALUresult_memory),
    .srcB_memory                     (srcB_memory),
    .rd_memory                       (rd_memory),
    .mem_req                         (mem_req),
    .mem_we                          (mem_we),
    .mem_addr                        (mem_addr),
    .mem_wdata                       (mem_wdata),
    .mem_ack                         (mem_ack),
    .mem_rdata                       (mem_rdata),
    .stall_memory                    (stall_memory),
    .wre_writeback                   (wre_writeback),
    .writeback_data                  (writeback_data),
    .rd_writeback                    (rd_writeback),
    .mem_error                       (mem_error)
  );

  always #5 clk = ~clk;

  task automatic check1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One instruction through the stage, entered at posedge+1 in IDLE.
  // ack_delay = n acks in the n-th ACCESS cycle; 0 or > TMO means never.
  task automatic run_instr(input logic ld, input logic st, input logic [15:0] alu,
                           input logic [15:0] srcb, input logic [15:0] rdv, input logic wre,
                           input int ack_delay, input logic [15:0] rdata, input logic spurious);
    logic        is_mem;
    logic        tmo;
    int          n_access;
    logic [15:0] exp_data;
    logic        exp_wre;
    is_mem   = ld | st;
    tmo      = !(ack_delay >= 1 && ack_delay <= int'(TMO));
    n_access = tmo ? int'(TMO) : ack_delay;
    exp_data = (!is_mem || st) ? alu : (tmo ? 16'h0000 : rdata);
    exp_wre  = st ? 1'b0 : wre;

    wre_memory                       = wre;
    select_writeback_data_mux_memory = ld;
    write_memory_enable_memory       = st;
    ALUresult_memory                 = alu;
    srcB_memory                      = srcb;
    rd_memory                        = rdv;
    mem_ack                          = spurious & ~is_mem;
    mem_rdata                        = 16'($urandom);
    #1;
    check1("stall_entry", stall_memory, is_mem);
    if (is_mem) begin
      for (int k = 1; k <= n_access; k++) begin
        @(posedge clk); #1;
        check1("req_access", mem_req, 1'b1);
        check1("we_access", mem_we, st);
        check16("addr_access", mem_addr, alu);
        check16("wdata_access", mem_wdata, srcb);
        check1("stall_access", stall_memory, 1'b1);
        check1("wre_access", wre_writeback, 1'b0);
        mem_ack   = (k == ack_delay);
        mem_rdata = (k == ack_delay) ? rdata : 16'($urandom);
      end
      @(posedge clk); #1;
      mem_ack = 1'b0;
      exp_err = exp_err | tmo;
      check1("req_done", mem_req, 1'b0);
      check1("stall_done", stall_memory, 1'b0);
      check1("err_done", mem_error, exp_err);
    end
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check16("wb_data", writeback_data, exp_data);
    check16("wb_rd", rd_writeback, rdv);
    check1("wb_wre", wre_writeback, exp_wre);
    check1("wb_err", mem_error, exp_err);
    check1("wb_req", mem_req, 1'b0);
  endtask

  initial begin
    reset                            = 1'b1;
    wre_memory                       = 1'b0;
    select_writeback_data_mux_memory = 1'b0;
    write_memory_enable_memory       = 1'b0;
    ALUresult_memory                 = 16'h0000;
    srcB_memory                      = 16'h0000;
    rd_memory                        = 16'h0000;
    mem_ack                          = 1'b0;
    mem_rdata                        = 16'h0000;
    #1;
    check1("rst_req", mem_req, 1'b0);
    check1("rst_we", mem_we, 1'b0);
    check16("rst_addr", mem_addr, 16'h0000);
    check16("rst_wdata", mem_wdata, 16'h0000);
    check1("rst_wre", wre_writeback, 1'b0);
    check16("rst_wbdata", writeback_data, 16'h0000);
    check16("rst_rd", rd_writeback, 16'h0000);
    check1("rst_err", mem_error, 1'b0);
    check1("rst_stall", stall_memory, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // ALU pass-through, load with ack on 2nd cycle, store with immediate ack
    run_instr(1'b0, 1'b0, 16'h1234, 16'h5555, 16'd3, 1'b1, 0, 16'h0000, 1'b0);
    run_instr(1'b1, 1'b0, 16'h0040, 16'h0000, 16'd5, 1'b1, 2, 16'hBEEF, 1'b0);
    run_instr(1'b0, 1'b1, 16'h0010, 16'h00AA, 16'd7, 1'b0, 1, 16'h0000, 1'b0);
    // both flags behave as a store; ack on the last allowed cycle beats timeout
    run_instr(1'b1, 1'b1, 16'h0020, 16'h1111, 16'd2, 1'b1, 1, 16'hCAFE, 1'b0);
    run_instr(1'b1, 1'b0, 16'h0030, 16'h0000, 16'd4, 1'b1, int'(TMO), 16'h7777, 1'b0);
    // spurious ack in IDLE, then a load that never gets acknowledged
    run_instr(1'b0, 1'b0, 16'hA5A5, 16'h0000, 16'd9, 1'b1, 0, 16'h0000, 1'b1);
    run_instr(1'b1, 1'b0, 16'h0050, 16'h0000, 16'd6, 1'b1, 0, 16'h9999, 1'b0);
    run_instr(1'b0, 1'b0, 16'h0101, 16'h0000, 16'd1, 1'b1, 0, 16'h0000, 1'b0);

    // reset in the middle of an access
    wre_memory                       = 1'b1;
    select_writeback_data_mux_memory = 1'b1;
    write_memory_enable_memory       = 1'b0;
    ALUresult_memory                 = 16'h0060;
    rd_memory                        = 16'd8;
    @(posedge clk); #1;
    check1("pre_rst_req", mem_req, 1'b1);
    reset = 1'b1;
    #1;
    check1("midrst_req", mem_req, 1'b0);
    check1("midrst_stall", stall_memory, 1'b0);
    check1("midrst_err", mem_error, 1'b0);
    exp_err                          = 1'b0;
    wre_memory                       = 1'b0;
    select_writeback_data_mux_memory = 1'b0;
    ALUresult_memory                 = 16'h0000;
    rd_memory                        = 16'h0000;
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check1("postrst_wre", wre_writeback, 1'b0);
    check1("postrst_req", mem_req, 1'b0);
    check1("postrst_stall", stall_memory, 1'b0);
    check16("postrst_data", writeback_data, 16'h0000);

    // random instruction stream
    for (int i = 0; i < 80; i++) begin
      int   kind;
      logic ld;
      logic st;
      kind = int'($urandom_range(0, 3));
      ld   = (kind == 1) || (kind == 3);
      st   = (kind == 2) || (kind == 3);
      run_instr(ld, st, 16'($urandom), 16'($urandom), 16'($urandom_range(0, 31)),
                1'($urandom), int'($urandom_range(0, TMO + 2)), 16'($urandom),
                1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/memory_access_unit.md
MEMORY_ACCESS_UNIT -- requirements
Module: memory_access_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15: max ACCESS cycles waited for mem_ack before abort.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 wre_memory  input  1  register-file write enable of instruction in memory stage.
REQ-005 select_writeback_data_mux_memory  input  1  1 = load instruction.
REQ-006 write_memory_enable_memory  input  1  1 = store instruction.
REQ-007 ALUresult_memory  input  16  ALU result / data address.
REQ-008 srcB_memory  input  16  store data.
REQ-009 rd_memory  input  16  destination register tag.
REQ-010 mem_req  output  1  data-memory request, registered.
REQ-011 mem_we  output  1  1 = write request, registered.
REQ-012 mem_addr  output  16  request address, registered.
REQ-013 mem_wdata  output  16  write data, registered.
REQ-014 mem_ack  input  1  memory completion strobe, one cycle.
REQ-015 mem_rdata  input  16  read data, valid when mem_ack=1.
REQ-016 stall_memory  output  1  freeze upstream pipeline registers.
REQ-017 wre_writeback  output  1  registered write enable to writeback stage.
REQ-018 writeback_data  output  16  registered ALU result or load data.
REQ-019 rd_writeback  output  16  registered destination tag.
REQ-020 mem_error  output  1  sticky timeout flag.

Function
REQ-021 FSM states IDLE, ACCESS, DONE; mem op = load or store flag set.
REQ-022 IDLE, no mem op: stall_memory=0; each edge writeback_data<=ALUresult_memory, rd_writeback<=rd_memory, wre_writeback<=wre_memory.
REQ-023 IDLE, mem op: stall_memory=1 combinationally; next edge -> ACCESS, mem_req<=1, mem_addr<=ALUresult_memory, mem_wdata<=srcB_memory, mem_we<=store flag, wre_writeback<=0.
REQ-024 ACCESS: stall_memory=1, wre_writeback=0; mem_req, mem_we, mem_addr, mem_wdata held stable until ack or timeout.
REQ-025 ACCESS with mem_ack=1: mem_req<=0, load data captured from mem_rdata, -> DONE.
REQ-026 DONE: stall_memory=0 for exactly one cycle; at its end edge writeback_data<=captured data (load) or ALUresult_memory (store), rd_writeback<=rd_memory, wre_writeback<=wre_memory for load, 0 for store; -> IDLE.
REQ-027 Load latency with ack in first ACCESS cycle: wre_writeback/writeback_data valid 3 edges after instruction enters memory stage.
REQ-028 Both load and store flags set: treated as store; wre_writeback=0 on completion.
REQ-029 Timeout counter clears on ACCESS entry, increments each ACCESS cycle without ack; on reaching TIMEOUT_CYCLES: mem_req<=0, mem_error<=1, captured data<=0, -> DONE.
REQ-030 mem_ack and timeout in same cycle: ack wins, no error.
REQ-031 mem_ack outside ACCESS: ignored, no state change.
REQ-032 mem_error sticky until reset.

Reset
REQ-033 reset=1 forces immediately, independent of clk: state IDLE; mem_req, mem_we, wre_writeback, mem_error =0; mem_addr, mem_wdata, writeback_data, rd_writeback, counter, captured data =0.
REQ-034 Reset mid-ACCESS drops mem_req in same cycle; no writeback of aborted instruction after release.
REQ-035 stall_memory=0 while reset asserted.

Structure
REQ-036 Shared CPU package holds state enum (IDLE, ACCESS, DONE) and WORD_W=16 constant.
REQ-037 Timeout counter is sub-module mem_timeout_counter (clear, enable, terminal-count output, TIMEOUT_CYCLES parameter).

Verification
REQ-038 ALU op ALUresult=0x1234, rd=3, wre=1, no mem op -> next edge writeback_data=0x1234, rd_writeback=3, wre_writeback=1, stall never 1.
REQ-039 Load addr 0x0040, ack after 2 ACCESS cycles with rdata 0xBEEF -> mem_req high 2 cycles, mem_we=0, stall high 3 cycles, then writeback_data=0xBEEF, wre_writeback=1 once.
REQ-040 Store addr 0x0010 data 0x00AA, immediate ack -> mem_we=1, mem_wdata=0x00AA, wre_writeback=0 throughout.
REQ-041 Load, no ack, TIMEOUT_CYCLES=4 -> mem_req drops after 4 ACCESS cycles, mem_error=1 and stays, writeback_data=0.
REQ-042 Reset asserted mid-ACCESS between edges -> mem_req=0 and stall_memory=0 before next edge; after release, state IDLE, no writeback.
REQ-043 Spurious mem_ack in IDLE with ALU op -> ignored; normal pass-through.
